// File: rtl/bcd_time_counter.sv
// bcd_time_counter: BCD time-of-day counter (HH:MM:SS) with a clk-cycle
// second divider, set-mode adjust strobes, 12/24-hour display mapping and
// day-wrap pulse. Optional alarm comparator compiled in with TIME_ALARM_EN;
// without it alarm_hit is tied low and alarm_hm is ignored.
module bcd_time_counter #(
  parameter int TICK_DIV = 50000000,
  parameter int DIV_W    = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        fmt12,
  input  logic        inc_sec,
  input  logic        inc_min,
  input  logic        inc_hr,
  input  logic [15:0] alarm_hm,
  output logic [23:0] time_data,
  output logic        pm,
  output logic        sec_tick,
  output logic        day_cy,
  output logic        alarm_hit
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  // Two-digit BCD increment wrapping 59 -> 00 (seconds and minutes).
  function automatic logic [7:0] inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Two-digit BCD increment wrapping 23 -> 00 (hours).
  function automatic logic [7:0] inc24(input logic [7:0] v);
    if (v == 8'h23)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Display mapping of the 24-hour count; storage is never touched.
  function automatic logic [7:0] hr_disp(input logic [7:0] h, input logic f);
    if (!f)
      return h;
    case (h)
      8'h00:   return 8'h12;
      8'h13:   return 8'h01;
      8'h14:   return 8'h02;
      8'h15:   return 8'h03;
      8'h16:   return 8'h04;
      8'h17:   return 8'h05;
      8'h18:   return 8'h06;
      8'h19:   return 8'h07;
      8'h20:   return 8'h08;
      8'h21:   return 8'h09;
      8'h22:   return 8'h10;
      8'h23:   return 8'h11;
      default: return h;
    endcase
  endfunction

  logic [DIV_W-1:0] div;
  logic [7:0]       sec, min, hr;
  logic [7:0]       sec_n, min_n, hr_n;
  logic             day_wrap;
  logic             alarm_match;

  // The tick is the last divider cycle; divider sits at 0 outside run.
  assign sec_tick = run && (div == DIV_LAST);

  // Second divider: counts while running, cleared in set mode and on reset.
  always_ff @(posedge clk) begin
    if (!rst)
      div <= '0;
    else if (!run || sec_tick)
      div <= '0;
    else
      div <= div + DIV_W'(1);
  end

  // Next time: ripple carry on a tick, independent field edits in set mode.
  always_comb begin
    sec_n    = sec;
    min_n    = min;
    hr_n     = hr;
    day_wrap = 1'b0;
    if (sec_tick) begin
      sec_n = inc60(sec);
      if (sec == 8'h59) begin
        min_n = inc60(min);
        if (min == 8'h59) begin
          hr_n = inc24(hr);
          day_wrap = (hr == 8'h23);
        end
      end
    end else if (!run) begin
      if (inc_sec) sec_n = 8'h00;
      if (inc_min) min_n = inc60(min);
      if (inc_hr)  hr_n  = inc24(hr);
    end
  end

`ifdef TIME_ALARM_EN
  logic alarm_valid;

  // Alarm only matches a legal BCD time, and only on a counted second, so
  // set-mode edits and reset can never raise it.
  always_comb begin
    alarm_valid = (alarm_hm[15:12] <= 4'd2) && (alarm_hm[11:8] <= 4'd9) &&
                  !((alarm_hm[15:12] == 4'd2) && (alarm_hm[11:8] > 4'd3)) &&
                  (alarm_hm[7:4] <= 4'd5) && (alarm_hm[3:0] <= 4'd9);
    alarm_match = sec_tick && alarm_valid &&
                  ({hr_n, min_n, sec_n} == {alarm_hm, 8'h00});
  end
`else
  logic unused_alarm_hm;

  // Comparator compiled out: input kept on the port list but unused.
  always_comb begin
    unused_alarm_hm = ^alarm_hm;
    alarm_match     = 1'b0;
  end
`endif

  // Time state plus registered display, pm and event pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sec       <= 8'h00;
      min       <= 8'h00;
      hr        <= 8'h00;
      time_data <= fmt12 ? 24'h120000 : 24'h000000;
      pm        <= 1'b0;
      day_cy    <= 1'b0;
      alarm_hit <= 1'b0;
    end else begin
      sec       <= sec_n;
      min       <= min_n;
      hr        <= hr_n;
      time_data <= {hr_disp(hr_n, fmt12), min_n, sec_n};
      pm        <= (hr_n >= 8'h12);
      day_cy    <= day_wrap;
      alarm_hit <= alarm_match;
    end
  end

endmodule

// File: doc/bcd_time_counter.md
BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000: clk cycles per second, legal range 2..2^DIV_W-1.
REQ-002 SHALL have parameter DIV_W, default 26: width of the second divider.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port run, input, 1: 1 = time counting, 0 = set mode.
REQ-006 SHALL have port fmt12, input, 1: 1 = 12-hour display, 0 = 24-hour display.
REQ-007 SHALL have ports inc_sec, inc_min and inc_hr, each input, 1: set-mode adjust strobes, sampled every cycle.
REQ-008 SHALL have port alarm_hm, input, 16: alarm time {H1,H0,M1,M0} in 24-hour BCD.
REQ-009 SHALL have port time_data, output, 24: {H1,H0,M1,M0,S1,S0}, one BCD digit per nibble, registered.
REQ-010 SHALL have port pm, output, 1: high when the internal hour is 12..23.
REQ-011 SHALL have port sec_tick, output, 1: one-cycle pulse per counted second.
REQ-012 SHALL have port day_cy, output, 1: one-cycle pulse on the 23:59:59 to 00:00:00 wrap.
REQ-013 SHALL have port alarm_hit, output, 1: one-cycle alarm pulse.

Function
REQ-014 Divider SHALL count 0..TICK_DIV-1 while run=1, then wrap to 0; sec_tick SHALL be high in the cycle the divider equals TICK_DIV-1.
REQ-015 While run=0 the divider SHALL be held at 0 and sec_tick SHALL be 0; the first sec_tick after run rises SHALL occur TICK_DIV cycles later.
REQ-016 On sec_tick, seconds SHALL advance in BCD 00..59; the 59 to 00 transition SHALL carry into minutes (00..59), and that carry SHALL carry into hours (00..23).
REQ-017 Updated time SHALL appear on time_data in the cycle after sec_tick (one-cycle latency).
REQ-018 day_cy SHALL pulse, in the same cycle the internal time becomes 00:00:00, only on that wrap.
REQ-019 Internal hours SHALL always be 24-hour. With fmt12=1, the hour field SHALL map 00 to 12, 13..23 to 01..11, and 01..12 unchanged. fmt12 SHALL affect only the output mapping, never the stored count, and SHALL take effect the next cycle.
REQ-020 In set mode, inc_sec SHALL clear seconds to 00.
REQ-021 In set mode, inc_min SHALL increment minutes modulo 60 with no carry into hours.
REQ-022 In set mode, inc_hr SHALL increment hours modulo 24.
REQ-023 Simultaneous inc strobes SHALL all be applied independently in the same cycle.
REQ-024 inc strobes SHALL be ignored while run=1.
REQ-025 A strobe held high SHALL increment once per cycle; edge detection is outside this block.
REQ-026 Every BCD digit SHALL remain valid (0..9) and within its field limits at all times.

Reset
REQ-027 rst=0 at a clock edge SHALL load time 00:00:00 and divider 0, and SHALL clear sec_tick, day_cy and alarm_hit.
REQ-028 After reset, time_data SHALL read 24'h000000 in 24-hour mode, or 24'h120000 with fmt12=1; pm SHALL read 0.
REQ-029 Reset mid-second SHALL discard the partial divider count and any pending carries.
REQ-030 Reset SHALL take priority over run and over the inc strobes.

Configuration
REQ-031 Macro TIME_ALARM_EN SHALL compile the alarm comparator in or out.
REQ-032 With TIME_ALARM_EN defined, alarm_hit SHALL pulse for one cycle when run=1 and the internal time becomes alarm_hm:00 through counting.
REQ-033 With TIME_ALARM_EN defined, alarm_hit SHALL NOT fire on set-mode edits or on reset.
REQ-034 With TIME_ALARM_EN defined, a non-BCD or out-of-range alarm_hm SHALL never match.
REQ-035 Without TIME_ALARM_EN, alarm_hit SHALL be tied 0, alarm_hm SHALL be ignored, and the port list SHALL be unchanged.

Verification (TICK_DIV=4)
REQ-036 Reset and tick rate: rst=0 for 2 cycles, then rst=1, run=1 -> time_data=24'h000000, then sec_tick every 4th cycle, and 24'h000001 one cycle after the first tick.
REQ-037 Day wrap: set mode with 23 inc_hr, 59 inc_min and inc_sec, then run=1 -> after 59 ticks time_data=24'h235959; next tick gives 24'h000000 and a single day_cy pulse.
REQ-038 12-hour display: internal 13:05:00 with fmt12=1 -> 24'h010500 and pm=1; internal 00:30:00 -> 24'h123000 and pm=0; fmt12=0 -> 24'h003000.
REQ-039 Set mode: at 10:59:30, inc_min -> 10:00:30; then inc_min and inc_hr in the same cycle -> 11:01:30; inc_min with run=1 -> no change.
REQ-040 Reset mid-run: rst=0 two cycles after a tick at 00:00:07 -> time_data=24'h000000, with the next tick 4 cycles after release.
REQ-041 Alarm (TIME_ALARM_EN): alarm_hm=16'h0001 with run from 00:00:58 -> alarm_hit for exactly one cycle as time becomes 00:01:00; setting the same time via inc strobes produces no pulse.
